// File: rtl/trigger_controller.sv
// trigger_controller
//   Arms on an ASCII command, waits for a masked rising edge on any trigger
//   channel (or a forced trigger), holds Capturing high for POST_SAMPLES
//   cycles, then either returns to idle (single-shot) or re-arms after a
//   HOLDOFF-cycle pause (continuous).
//
// Ports
//   Clock        in   single rising-edge clock
//   Reset        in   asynchronous, active-high
//   Cmd          in   ASCII command byte
//                     'A' arm, 'a' abort, 'F' force, 'S' single-shot,
//                     'C' continuous, 'M' next byte is the channel mask
//   CmdValid     in   Cmd qualifier
//   TrigIn       in   per-channel trigger level, synchronous to Clock
//   TriggerArmed out  high while armed
//   Capturing    out  high while capturing
//   Triggered    out  one-cycle pulse on arming -> capture
//   CaptureDone  out  one-cycle pulse when a capture completes normally
//   TrigSource   out  channels behind the last trigger (zero when forced)
//   ContMode     out  0 = single-shot, 1 = continuous
module trigger_controller #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned POST_SAMPLES = 512,
    parameter int unsigned HOLDOFF      = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [7:0]        Cmd,
    input  logic              CmdValid,
    input  logic [NUM_CH-1:0] TrigIn,
    output logic              TriggerArmed,
    output logic              Capturing,
    output logic              Triggered,
    output logic              CaptureDone,
    output logic [NUM_CH-1:0] TrigSource,
    output logic              ContMode
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_HOLDOFF
    } state_t;

    localparam logic [15:0] POST_LOAD = 16'(POST_SAMPLES - 1);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF - 1);

    state_t            state;
    logic [15:0]       cnt;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] trig_prev;
    logic              mask_pending;

    logic              cmd_live;
    logic              cmd_arm;
    logic              cmd_abort;
    logic              cmd_force;
    logic              cmd_single;
    logic              cmd_cont;
    logic              cmd_mask;
    logic [NUM_CH-1:0] hit;
    logic              any_hit;

    // A byte that follows 'M' is mask data and never reaches the decoder.
    always_comb begin
        cmd_live   = CmdValid & ~mask_pending;
        cmd_arm    = cmd_live && (Cmd == 8'h41);
        cmd_abort  = cmd_live && (Cmd == 8'h61);
        cmd_force  = cmd_live && (Cmd == 8'h46);
        cmd_single = cmd_live && (Cmd == 8'h53);
        cmd_cont   = cmd_live && (Cmd == 8'h43);
        cmd_mask   = cmd_live && (Cmd == 8'h4D);
        hit        = TrigIn & ~trig_prev & ch_mask;
        any_hit    = |hit;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ch_mask      <= '1;
            trig_prev    <= '1;
            mask_pending <= 1'b0;
            TriggerArmed <= 1'b0;
            Capturing    <= 1'b0;
            Triggered    <= 1'b0;
            CaptureDone  <= 1'b0;
            TrigSource   <= '0;
            ContMode     <= 1'b0;
        end else begin
            trig_prev   <= TrigIn;
            Triggered   <= 1'b0;
            CaptureDone <= 1'b0;

            if (CmdValid && mask_pending) begin
                ch_mask      <= Cmd[NUM_CH-1:0];
                mask_pending <= 1'b0;
            end
            if (cmd_mask)   mask_pending <= 1'b1;
            if (cmd_single) ContMode     <= 1'b0;
            if (cmd_cont)   ContMode     <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_arm) begin
                        state        <= ST_ARMED;
                        TriggerArmed <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // Abort wins over a hit; a hit wins over a force.
                    if (cmd_abort) begin
                        state        <= ST_IDLE;
                        TriggerArmed <= 1'b0;
                    end else if (any_hit || cmd_force) begin
                        state        <= ST_CAPTURE;
                        TriggerArmed <= 1'b0;
                        Capturing    <= 1'b1;
                        Triggered    <= 1'b1;
                        TrigSource   <= any_hit ? hit : '0;
                        cnt          <= POST_LOAD;
                    end
                end
                ST_CAPTURE: begin
                    // ContMode is sampled here, so a mode change made during
                    // the capture takes effect at its end.
                    if (cmd_abort) begin
                        state     <= ST_IDLE;
                        Capturing <= 1'b0;
                    end else if (cnt == 16'd0) begin
                        Capturing   <= 1'b0;
                        CaptureDone <= 1'b1;
                        if (ContMode) begin
                            state <= ST_HOLDOFF;
                            cnt   <= HOLD_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cmd_abort) begin
                        state <= ST_IDLE;
                    end else if (cnt == 16'd0) begin
                        state        <= ST_ARMED;
                        TriggerArmed <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    TriggerArmed <= 1'b0;
                    Capturing    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_controller.sv
// tb_trigger_controller
//   Self-checking bench for trigger_controller (default parameters).
//   Expected Triggered/CaptureDone pulses are queued as stimulus is driven
//   and matched by a negedge monitor; level outputs are checked inline.
module tb_trigger_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Cmd = 8'h00;
    logic       CmdValid = 1'b0;
    logic [3:0] TrigIn = 4'h0;
    logic       TriggerArmed;
    logic       Capturing;
    logic       Triggered;
    logic       CaptureDone;
    logic [3:0] TrigSource;
    logic       ContMode;

    trigger_controller #(
        .NUM_CH(4),
        .POST_SAMPLES(512),
        .HOLDOFF(16)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Cmd(Cmd),
        .CmdValid(CmdValid),
        .TrigIn(TrigIn),
        .TriggerArmed(TriggerArmed),
        .Capturing(Capturing),
        .Triggered(Triggered),
        .CaptureDone(CaptureDone),
        .TrigSource(TrigSource),
        .ContMode(ContMode)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit         is_done;
        logic [3:0] src;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    // Scoreboard: every pulse must match the oldest expected event.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (Triggered) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_trig unexpected Triggered got src=%h exp no pulse", TrigSource);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    if (e.is_done !== 1'b0 || TrigSource !== e.src) begin
                        n_err++;
                        $display("FAIL sb_trig got trig src=%h exp done=%0d src=%h",
                                 TrigSource, e.is_done, e.src);
                    end
                end
            end
            if (CaptureDone) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_done unexpected CaptureDone got 1 exp no pulse");
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    if (e.is_done !== 1'b1) begin
                        n_err++;
                        $display("FAIL sb_done got CaptureDone exp trig src=%h", e.src);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        Cmd      = c;
        CmdValid = 1'b1;
        tick();
        CmdValid = 1'b0;
        Cmd      = 8'h00;
    endtask

    task automatic push_ev(input bit is_done, input logic [3:0] src);
        ev_t e;
        e.is_done = is_done;
        e.src     = src;
        sb.push_back(e);
    endtask

    // Caller is already observing capture cycle number 'start'.
    task automatic wait_capture_end(input int start, output int cycles);
        cycles = start;
        for (int i = 0; i < 2000 && Capturing; i++) begin
            tick();
            if (Capturing) cycles++;
        end
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        TrigIn = 4'hF;
        tick();
        tick();
        n_cmp++;
        if ({TriggerArmed, Capturing, Triggered, CaptureDone, TrigSource, ContMode} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs got %b exp 0",
                     {TriggerArmed, Capturing, Triggered, CaptureDone, TrigSource, ContMode});
        end
        Reset = 1'b0;
        tick();
        send_cmd(8'h41);
        n_cmp++;
        if (TriggerArmed !== 1'b1) begin
            n_err++;
            $display("FAIL reset_arm got %b exp 1", TriggerArmed);
        end
        repeat (3) tick();
        n_cmp++;
        if (TriggerArmed !== 1'b1 || Capturing !== 1'b0) begin
            n_err++;
            $display("FAIL held_high_no_trig got armed=%b cap=%b exp armed=1 cap=0",
                     TriggerArmed, Capturing);
        end
        send_cmd(8'h61);
        TrigIn = 4'h0;
        tick();
    endtask

    task automatic test_single_shot();
        int c;
        send_cmd(8'h41);
        n_cmp++;
        if (TriggerArmed !== 1'b1) begin
            n_err++;
            $display("FAIL ss_armed got %b exp 1", TriggerArmed);
        end
        TrigIn = 4'b0100;
        push_ev(1'b0, 4'b0100);
        push_ev(1'b1, 4'b0000);
        tick();
        n_cmp++;
        if (Triggered !== 1'b1 || Capturing !== 1'b1 || TrigSource !== 4'b0100 || TriggerArmed !== 1'b0) begin
            n_err++;
            $display("FAIL ss_trigger got trg=%b cap=%b src=%h armed=%b exp 1 1 4 0",
                     Triggered, Capturing, TrigSource, TriggerArmed);
        end
        wait_capture_end(1, c);
        n_cmp++;
        if (c !== 512) begin
            n_err++;
            $display("FAIL ss_capture_len got %0d exp 512", c);
        end
        n_cmp++;
        if (CaptureDone !== 1'b1 || TriggerArmed !== 1'b0 || Capturing !== 1'b0) begin
            n_err++;
            $display("FAIL ss_done got done=%b armed=%b cap=%b exp 1 0 0",
                     CaptureDone, TriggerArmed, Capturing);
        end
        tick();
        n_cmp++;
        if (CaptureDone !== 1'b0 || TriggerArmed !== 1'b0) begin
            n_err++;
            $display("FAIL ss_idle got done=%b armed=%b exp 0 0", CaptureDone, TriggerArmed);
        end
        TrigIn = 4'h0;
        tick();
    endtask

    task automatic test_continuous();
        int c;
        int h;
        send_cmd(8'h43);
        n_cmp++;
        if (ContMode !== 1'b1) begin
            n_err++;
            $display("FAIL cont_mode got %b exp 1", ContMode);
        end
        send_cmd(8'h41);
        TrigIn = 4'b0001;
        push_ev(1'b0, 4'b0001);
        push_ev(1'b1, 4'b0000);
        tick();
        wait_capture_end(1, c);
        n_cmp++;
        if (c !== 512 || CaptureDone !== 1'b1 || TriggerArmed !== 1'b0) begin
            n_err++;
            $display("FAIL cont_capture got len=%0d done=%b armed=%b exp 512 1 0",
                     c, CaptureDone, TriggerArmed);
        end
        h = 1;
        for (int i = 0; i < 100; i++) begin
            TrigIn[0] = ~TrigIn[0];
            tick();
            if (TriggerArmed) break;
            h++;
        end
        TrigIn = 4'h0;
        n_cmp++;
        if (h !== 16 || TriggerArmed !== 1'b1) begin
            n_err++;
            $display("FAIL cont_holdoff got len=%0d armed=%b exp 16 1", h, TriggerArmed);
        end
        tick();
        TrigIn = 4'b0010;
        push_ev(1'b0, 4'b0010);
        push_ev(1'b1, 4'b0000);
        tick();
        n_cmp++;
        if (Triggered !== 1'b1 || TrigSource !== 4'b0010) begin
            n_err++;
            $display("FAIL cont_retrigger got trg=%b src=%h exp 1 2", Triggered, TrigSource);
        end
        send_cmd(8'h53);
        n_cmp++;
        if (ContMode !== 1'b0 || Capturing !== 1'b1) begin
            n_err++;
            $display("FAIL cont_mode_change got mode=%b cap=%b exp 0 1", ContMode, Capturing);
        end
        wait_capture_end(2, c);
        n_cmp++;
        if (c !== 512 || CaptureDone !== 1'b1) begin
            n_err++;
            $display("FAIL cont_second_len got len=%0d done=%b exp 512 1", c, CaptureDone);
        end
        repeat (20) tick();
        n_cmp++;
        if (TriggerArmed !== 1'b0 || Capturing !== 1'b0) begin
            n_err++;
            $display("FAIL cont_single_end got armed=%b cap=%b exp 0 0", TriggerArmed, Capturing);
        end
        TrigIn = 4'h0;
        tick();
    endtask

    task automatic test_mask();
        send_cmd(8'h4D);
        send_cmd(8'h02);
        send_cmd(8'h41);
        n_cmp++;
        if (TriggerArmed !== 1'b1) begin
            n_err++;
            $display("FAIL mask_arm got %b exp 1", TriggerArmed);
        end
        TrigIn = 4'b0001;
        tick();
        tick();
        n_cmp++;
        if (TriggerArmed !== 1'b1 || Capturing !== 1'b0) begin
            n_err++;
            $display("FAIL mask_blocked got armed=%b cap=%b exp 1 0", TriggerArmed, Capturing);
        end
        TrigIn = 4'b0011;
        push_ev(1'b0, 4'b0010);
        tick();
        n_cmp++;
        if (Triggered !== 1'b1 || TrigSource !== 4'b0010) begin
            n_err++;
            $display("FAIL mask_pass got trg=%b src=%h exp 1 2", Triggered, TrigSource);
        end
        send_cmd(8'h61);
        n_cmp++;
        if (Capturing !== 1'b0 || TriggerArmed !== 1'b0 || CaptureDone !== 1'b0 || TrigSource !== 4'b0010) begin
            n_err++;
            $display("FAIL capture_abort got cap=%b armed=%b done=%b src=%h exp 0 0 0 2",
                     Capturing, TriggerArmed, CaptureDone, TrigSource);
        end
        TrigIn = 4'h0;
        send_cmd(8'h4D);
        send_cmd(8'h41);
        tick();
        n_cmp++;
        if (TriggerArmed !== 1'b0) begin
            n_err++;
            $display("FAIL mask_byte_no_arm got %b exp 0", TriggerArmed);
        end
        send_cmd(8'h4D);
        send_cmd(8'hFF);
        tick();
    endtask

    task automatic test_collision();
        send_cmd(8'h41);
        Cmd      = 8'h61;
        CmdValid = 1'b1;
        TrigIn   = 4'b1000;
        tick();
        CmdValid = 1'b0;
        Cmd      = 8'h00;
        n_cmp++;
        if (TriggerArmed !== 1'b0 || Capturing !== 1'b0 || Triggered !== 1'b0) begin
            n_err++;
            $display("FAIL abort_beats_hit got armed=%b cap=%b trg=%b exp 0 0 0",
                     TriggerArmed, Capturing, Triggered);
        end
        TrigIn = 4'h0;
        tick();
        send_cmd(8'h41);
        Cmd      = 8'h46;
        CmdValid = 1'b1;
        TrigIn   = 4'b1000;
        push_ev(1'b0, 4'b1000);
        tick();
        CmdValid = 1'b0;
        Cmd      = 8'h00;
        n_cmp++;
        if (Triggered !== 1'b1 || TrigSource !== 4'b1000) begin
            n_err++;
            $display("FAIL hit_beats_force got trg=%b src=%h exp 1 8", Triggered, TrigSource);
        end
        send_cmd(8'h61);
        TrigIn = 4'h0;
        tick();
        send_cmd(8'h41);
        push_ev(1'b0, 4'b0000);
        send_cmd(8'h46);
        n_cmp++;
        if (Triggered !== 1'b1 || Capturing !== 1'b1 || TrigSource !== 4'b0000) begin
            n_err++;
            $display("FAIL force_trigger got trg=%b cap=%b src=%h exp 1 1 0",
                     Triggered, Capturing, TrigSource);
        end
        repeat (99) tick();
        send_cmd(8'h61);
        n_cmp++;
        if (Capturing !== 1'b0 || TriggerArmed !== 1'b0 || CaptureDone !== 1'b0) begin
            n_err++;
            $display("FAIL abort_cycle100 got cap=%b armed=%b done=%b exp 0 0 0",
                     Capturing, TriggerArmed, CaptureDone);
        end
        repeat (10) tick();
    endtask

    task automatic test_reset_holdoff();
        int c;
        send_cmd(8'h43);
        send_cmd(8'h41);
        push_ev(1'b0, 4'b0000);
        push_ev(1'b1, 4'b0000);
        send_cmd(8'h46);
        wait_capture_end(1, c);
        repeat (3) tick();
        n_cmp++;
        if (TriggerArmed !== 1'b0 || Capturing !== 1'b0 || ContMode !== 1'b1) begin
            n_err++;
            $display("FAIL holdoff_state got armed=%b cap=%b mode=%b exp 0 0 1",
                     TriggerArmed, Capturing, ContMode);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({TriggerArmed, Capturing, Triggered, CaptureDone, TrigSource, ContMode} !== 9'b0) begin
            n_err++;
            $display("FAIL async_reset got %b exp 0",
                     {TriggerArmed, Capturing, Triggered, CaptureDone, TrigSource, ContMode});
        end
        tick();
        Reset = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if (TriggerArmed !== 1'b0 || ContMode !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_rearm got armed=%b mode=%b exp 0 0", TriggerArmed, ContMode);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_mask();
        test_collision();
        test_reset_holdoff();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got %0d pending exp 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trigger_controller.md
TRIGGER_CONTROLLER -- requirements
Module: trigger_controller

Interface
REQ-001 Parameter NUM_CH, default 4, number of trigger input channels; legal range 1..8.
REQ-002 Parameter POST_SAMPLES, default 512, post-trigger capture length in clock cycles; legal range 1..65535.
REQ-003 Parameter HOLDOFF, default 16, cycles between capture end and automatic re-arm in continuous mode; legal range 1..65535.
REQ-004 Clock  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of Clock.
REQ-006 Cmd  input  8  ASCII command byte.
REQ-007 CmdValid  input  1  Cmd is consumed on a cycle where CmdValid=1; ignored otherwise.
REQ-008 TrigIn  input  NUM_CH  per-channel trigger hit, level signal, synchronous to Clock.
REQ-009 TriggerArmed  output  1  high while in ARMED.
REQ-010 Capturing  output  1  high while in CAPTURE.
REQ-011 Triggered  output  1  one-cycle pulse on the ARMED->CAPTURE edge.
REQ-012 CaptureDone  output  1  one-cycle pulse when a capture completes normally.
REQ-013 TrigSource  output  NUM_CH  channels that caused the last trigger; all zeros for a forced trigger.
REQ-014 ContMode  output  1  0 = single-shot, 1 = continuous.

Function
REQ-015 States: IDLE, ARMED, CAPTURE, HOLDOFF; all outputs are registered.
REQ-016 Commands (CmdValid=1, no mask pending): 'A' (65) arm; 'a' (97) disarm/abort; 'F' (70) force trigger; 'S' (83) ContMode<=0; 'C' (67) ContMode<=1; 'M' (77) set MaskPending; all other bytes ignored.
REQ-017 With MaskPending=1, the next valid byte loads ChMask<=Cmd[NUM_CH-1:0], clears MaskPending and is not decoded as a command; the mask is internal state.
REQ-018 Edge detect: per channel, Hit = TrigIn & ~TrigPrev & ChMask, with TrigPrev <= TrigIn every cycle.
REQ-019 IDLE: 'A' -> ARMED next cycle; Hit and 'F' are ignored.
REQ-020 ARMED: 'a' -> IDLE; otherwise |Hit or 'F' -> CAPTURE, with Triggered=1 for one cycle, TrigSource<=Hit ('F' gives 0), counter loaded POST_SAMPLES-1.
REQ-021 CAPTURE: the counter decrements each cycle; at counter 0, CaptureDone pulses for one cycle and the next state is IDLE (ContMode=0) or HOLDOFF (ContMode=1, counter loaded HOLDOFF-1).
REQ-022 Capturing is high for exactly POST_SAMPLES cycles per trigger.
REQ-023 HOLDOFF: Hit and 'F' are ignored; counter decrements; at 0 -> ARMED.
REQ-024 'a' in CAPTURE or HOLDOFF -> IDLE next cycle; no CaptureDone pulse; TrigSource is retained.
REQ-025 Simultaneous events in ARMED: 'a' beats Hit; Hit beats 'F' (TrigSource=Hit).
REQ-026 'A' in ARMED, CAPTURE or HOLDOFF has no effect; a mode change ('S'/'C') during CAPTURE applies at the capture end.
REQ-027 A byte consumed as a mask value never causes a state transition.
REQ-028 Counter width is 16 bits; it never wraps below 0.

Reset
REQ-029 While Reset=1: state IDLE, TriggerArmed=0, Capturing=0, Triggered=0, CaptureDone=0, TrigSource=0, ContMode=0, ChMask=all ones, MaskPending=0, counter=0, TrigPrev=all ones (so a TrigIn held high through reset does not trigger).
REQ-030 Reset asserted mid-capture aborts immediately; no CaptureDone pulse.

Verification
REQ-031 Single shot: reset; 'A'; TrigIn[2] rises -> Triggered pulse the cycle after the edge, TrigSource=4'b0100, Capturing high for 512 cycles, CaptureDone pulse, state IDLE, TriggerArmed=0.
REQ-032 Continuous: 'C', 'A', TrigIn[0] rise -> capture of 512 cycles, 16 holdoff cycles with TrigIn toggling and no trigger, then TriggerArmed=1; a second edge retriggers.
REQ-033 Mask: 'M', 0x02, 'A'; TrigIn[0] rises -> no trigger; TrigIn[1] rises -> TrigSource=4'b0010; a mask byte equal to 0x41 ('A') does not arm.
REQ-034 Collision: in ARMED, 'a' and a TrigIn[3] edge in the same cycle -> IDLE, no Triggered pulse; 'F' alone in ARMED -> TrigSource=0.
REQ-035 Abort/reset: 'a' at capture cycle 100 -> IDLE, no CaptureDone; asynchronous Reset mid-HOLDOFF -> all outputs at reset values before the next Clock edge; TrigIn held high across reset release -> no trigger after 'A'.
